// File: rtl/inst_trace_buffer.sv
// Retired-instruction trace buffer: circular capture with stop/overwrite modes,
// masked-match trigger with post-trigger freeze, and a decoded valid/ready drain.
module inst_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int STAMP_W   = 16,
  parameter int WRAP      = 0,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [31:0]                in_inst,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       arm,
  input  logic [31:0]                trig_mask,
  input  logic [31:0]                trig_match,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic [STAMP_W-1:0]         out_stamp,
  output logic [2:0]                 out_class,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [31:0]                out_imm,
  output logic [25:0]                out_jidx,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                dropped,
  output logic [1:0]                 state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_FROZEN  = 2'd3
  } state_t;

  state_t             r_state;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [15:0]        r_dropped;
  logic [STAMP_W-1:0] r_stamp;
  logic [PW-1:0]      r_post;

  logic [31:0]        r_mem_inst  [DEPTH];
  logic [PC_W-1:0]    r_mem_pc    [DEPTH];
  logic [STAMP_W-1:0] r_mem_stamp [DEPTH];

  logic w_capturing;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_write;
  logic w_drop;
  logic w_rd_adv;
  logic w_trig;
  logic w_post_done;

  logic [31:0]        w_head_inst;
  logic [PC_W-1:0]    w_head_pc;
  logic [STAMP_W-1:0] w_head_stamp;

  function automatic logic [2:0] f_class(input logic [31:0] inst);
    logic [2:0] cls;
    if (inst == 32'd0) begin
      cls = 3'd0;
    end else begin
      case (inst[31:26])
        6'd0:       cls = 3'd1;
        6'd1:       cls = 3'd2;
        6'd2, 6'd3: cls = 3'd3;
        default:    cls = 3'd4;
      endcase
    end
    return cls;
  endfunction

  // andi/ori/xori take a zero-extended immediate; everything else sign-extends
  function automatic logic [31:0] f_imm(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[31:26])
      6'h0C, 6'h0D, 6'h0E: imm = {16'd0, inst[15:0]};
      default:             imm = {{16{inst[15]}}, inst[15:0]};
    endcase
    return imm;
  endfunction

  assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_push      = in_valid && w_capturing && !arm;
  assign w_empty     = (r_count == CW'(0));
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = !w_empty && out_ready;
  assign w_write     = w_push && (!w_full || w_pop || (WRAP != 0));
  assign w_drop      = w_push && w_full && !w_pop && (WRAP == 0);
  // An overwriting push and a pop share a single read-pointer advance
  assign w_rd_adv    = w_pop || (w_push && w_full && (WRAP != 0));
  assign w_trig      = w_write && (r_state == ST_CAPTURE) &&
                       (((in_inst ^ trig_match) & trig_mask) == 32'd0);
  assign w_post_done = (r_post == PW'(1));

  // Control state, pointers, occupancy, drop counter, stamp and post counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_dropped <= 16'd0;
      r_stamp   <= '0;
      r_post    <= '0;
    end else if (arm) begin
      r_state   <= ST_CAPTURE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_dropped <= 16'd0;
      r_stamp   <= '0;
      r_post    <= '0;
    end else begin
      r_stamp <= r_stamp + STAMP_W'(1);
      if (w_write) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_adv) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_write, w_rd_adv})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
      case (r_state)
        ST_CAPTURE: begin
          if (w_trig) begin
            if (POST_TRIG == 0) begin
              r_state <= ST_FROZEN;
            end else begin
              r_state <= ST_POST;
              r_post  <= PW'(POST_TRIG);
            end
          end
        end
        ST_POST: begin
          if (w_write) begin
            r_post <= r_post - PW'(1);
            if (w_post_done) begin
              r_state <= ST_FROZEN;
            end
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Entry storage; contents are left unreset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_inst[r_wptr]  <= in_inst;
      r_mem_pc[r_wptr]    <= in_pc;
      r_mem_stamp[r_wptr] <= r_stamp;
    end
  end

  assign w_head_inst  = w_empty ? 32'd0 : r_mem_inst[r_rptr];
  assign w_head_pc    = w_empty ? '0    : r_mem_pc[r_rptr];
  assign w_head_stamp = w_empty ? '0    : r_mem_stamp[r_rptr];

  // Show-ahead head view with combinational decode
  always_comb begin
    out_inst   = w_head_inst;
    out_pc     = w_head_pc;
    out_stamp  = w_head_stamp;
    out_class  = f_class(w_head_inst);
    out_opcode = w_head_inst[31:26];
    out_rs     = w_head_inst[25:21];
    out_rt     = w_head_inst[20:16];
    out_rd     = w_head_inst[15:11];
    out_shamt  = w_head_inst[10:6];
    out_funct  = w_head_inst[5:0];
    out_imm    = f_imm(w_head_inst);
    out_jidx   = w_head_inst[25:0];
  end

  assign out_valid = !w_empty;
  assign count     = r_count;
  assign dropped   = r_dropped;
  assign state     = r_state;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: a stop-when-full and an overwrite instance share
// stimulus and are checked every cycle against a list-based reference model.
module tb_inst_trace_buffer;

  localparam int DEPTH = 16;
  localparam int POST_TRIG = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] JUMP = 32'h08100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, arm = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = 32'd0, in_pc = 32'd0, trig_mask = 32'd0, trig_match = 32'd0;

  logic d0_valid, d1_valid;
  logic [31:0] d0_inst, d1_inst, d0_pc, d1_pc, d0_imm, d1_imm;
  logic [15:0] d0_stamp, d1_stamp, d0_dropped, d1_dropped;
  logic [2:0] d0_class, d1_class;
  logic [5:0] d0_opcode, d1_opcode, d0_funct, d1_funct;
  logic [4:0] d0_rs, d1_rs, d0_rt, d1_rt, d0_rd, d1_rd, d0_shamt, d1_shamt;
  logic [25:0] d0_jidx, d1_jidx;
  logic [CW-1:0] d0_count, d1_count;
  logic [1:0] d0_state, d1_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inst_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .STAMP_W(16), .WRAP(0), .POST_TRIG(POST_TRIG)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .arm(arm),
    .trig_mask(trig_mask), .trig_match(trig_match), .out_valid(d0_valid), .out_ready(out_ready),
    .out_inst(d0_inst), .out_pc(d0_pc), .out_stamp(d0_stamp), .out_class(d0_class),
    .out_opcode(d0_opcode), .out_rs(d0_rs), .out_rt(d0_rt), .out_rd(d0_rd), .out_shamt(d0_shamt),
    .out_funct(d0_funct), .out_imm(d0_imm), .out_jidx(d0_jidx), .count(d0_count),
    .dropped(d0_dropped), .state(d0_state));

  inst_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .STAMP_W(16), .WRAP(1), .POST_TRIG(POST_TRIG)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .arm(arm),
    .trig_mask(trig_mask), .trig_match(trig_match), .out_valid(d1_valid), .out_ready(out_ready),
    .out_inst(d1_inst), .out_pc(d1_pc), .out_stamp(d1_stamp), .out_class(d1_class),
    .out_opcode(d1_opcode), .out_rs(d1_rs), .out_rt(d1_rt), .out_rd(d1_rd), .out_shamt(d1_shamt),
    .out_funct(d1_funct), .out_imm(d1_imm), .out_jidx(d1_jidx), .count(d1_count),
    .dropped(d1_dropped), .state(d1_state));

  // Reference model: per instance an ordered list (index 0 = oldest entry)
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [15:0] stamp;
  } ent_t;

  ent_t mbuf [2][DEPTH];
  int msize [2];
  int mdrop [2];
  int mstate [2];
  int mpost [2];
  int mstamp;

  function automatic logic [2:0] exp_class(input logic [31:0] inst);
    if (inst == 32'd0) return 3'd0;
    if (inst[31:26] == 6'd0) return 3'd1;
    if (inst[31:26] == 6'd1) return 3'd2;
    if (inst[31:26] == 6'd2 || inst[31:26] == 6'd3) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] inst);
    if (inst[31:26] >= 6'h0C && inst[31:26] <= 6'h0E) return {16'd0, inst[15:0]};
    return {{16{inst[15]}}, inst[15:0]};
  endfunction

  task automatic model_clear(input int st);
    for (int k = 0; k < 2; k++) begin
      msize[k] = 0;
      mdrop[k] = 0;
      mstate[k] = st;
      mpost[k] = 0;
    end
    mstamp = 0;
  endtask

  task automatic pop_front(input int k);
    for (int i = 0; i < msize[k] - 1; i++) mbuf[k][i] = mbuf[k][i + 1];
    msize[k] = msize[k] - 1;
  endtask

  task automatic model_step(input int k, input bit wrap);
    bit pop, push, full, wr;
    int st;
    ent_t e;
    st = mstate[k];
    pop = (msize[k] != 0) && out_ready;
    push = in_valid && (st == 1 || st == 2);
    full = (msize[k] == DEPTH);
    wr = 1'b0;
    if (push && full && !wrap && !pop) begin
      if (mdrop[k] < 65535) mdrop[k] = mdrop[k] + 1;
    end else begin
      if (pop || (push && full)) pop_front(k);
      if (push) begin
        e.inst = in_inst;
        e.pc = in_pc;
        e.stamp = 16'(mstamp);
        mbuf[k][msize[k]] = e;
        msize[k] = msize[k] + 1;
        wr = 1'b1;
      end
    end
    if (wr && st == 1 && (((in_inst ^ trig_match) & trig_mask) == 32'd0)) begin
      if (POST_TRIG == 0) mstate[k] = 3;
      else begin
        mstate[k] = 2;
        mpost[k] = POST_TRIG;
      end
    end else if (wr && st == 2) begin
      mpost[k] = mpost[k] - 1;
      if (mpost[k] == 0) mstate[k] = 3;
    end
  endtask

  initial begin
    model_clear(0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear(0);
      else if (arm) model_clear(1);
      else begin
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        mstamp = (mstamp + 1) % 65536;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input int k, input logic ov, input logic [31:0] oinst, input logic [31:0] opc,
                         input logic [15:0] ostamp, input logic [2:0] ocls, input logic [5:0] oop,
                         input logic [4:0] ors, input logic [4:0] ort, input logic [4:0] ord,
                         input logic [4:0] osh, input logic [5:0] ofn, input logic [31:0] oimm,
                         input logic [25:0] ojidx, input logic [CW-1:0] ocnt,
                         input logic [15:0] odrop, input logic [1:0] ost);
    ent_t e;
    logic [31:0] ei;
    e = (msize[k] != 0) ? mbuf[k][0] : '0;
    ei = e.inst;
    chk("valid", k, 32'(ov), 32'(msize[k] != 0));
    chk("count", k, 32'(ocnt), 32'(msize[k]));
    chk("dropped", k, 32'(odrop), 32'(mdrop[k]));
    chk("state", k, 32'(ost), 32'(mstate[k]));
    chk("inst", k, oinst, ei);
    chk("pc", k, opc, e.pc);
    chk("stamp", k, 32'(ostamp), 32'(e.stamp));
    chk("class", k, 32'(ocls), 32'(exp_class(ei)));
    chk("opcode", k, 32'(oop), 32'(ei[31:26]));
    chk("rs", k, 32'(ors), 32'(ei[25:21]));
    chk("rt", k, 32'(ort), 32'(ei[20:16]));
    chk("rd", k, 32'(ord), 32'(ei[15:11]));
    chk("shamt", k, 32'(osh), 32'(ei[10:6]));
    chk("funct", k, 32'(ofn), 32'(ei[5:0]));
    chk("imm", k, oimm, (ei == 32'd0) ? 32'd0 : exp_imm(ei));
    chk("jidx", k, 32'(ojidx), 32'(ei[25:0]));
  endtask

  // Every-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      cmp_all(0, d0_valid, d0_inst, d0_pc, d0_stamp, d0_class, d0_opcode, d0_rs, d0_rt, d0_rd,
              d0_shamt, d0_funct, d0_imm, d0_jidx, d0_count, d0_dropped, d0_state);
      cmp_all(1, d1_valid, d1_inst, d1_pc, d1_stamp, d1_class, d1_opcode, d1_rs, d1_rt, d1_rd,
              d1_shamt, d1_funct, d1_imm, d1_jidx, d1_count, d1_dropped, d1_state);
    end
  end

  task automatic cyc(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                     input bit rdy, input bit a);
    in_valid = v;
    in_inst = inst;
    in_pc = pc;
    out_ready = rdy;
    arm = a;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    arm = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("lit_rst_state", 0, 32'(d0_state), 32'd0);
    chk("lit_rst_valid", 0, 32'(d0_valid), 32'd0);
    rst_n = 1'b1;
    cyc(1'b1, ADDU, 32'h10, 1'b0, 1'b0);
    chk("lit_idle_ignore", 0, 32'(d0_count), 32'd0);

    // Basic capture and decode
    trig_mask = 32'hFFFFFFFF;
    trig_match = 32'hDEADBEEF;
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("lit_arm_state", 0, 32'(d0_state), 32'd1);
    cyc(1'b1, 32'h00000000, 32'h400000, 1'b0, 1'b0);
    cyc(1'b1, 32'h012A4020, 32'h400004, 1'b0, 1'b0);
    cyc(1'b1, 32'h3C011001, 32'h400008, 1'b0, 1'b0);
    chk("lit_count3", 0, 32'(d0_count), 32'd3);
    chk("lit_cls_nop", 0, 32'(d0_class), 32'd0);
    chk("lit_pc0", 0, d0_pc, 32'h400000);
    chk("lit_stamp0", 0, 32'(d0_stamp), 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lit_cls_r", 0, 32'(d0_class), 32'd1);
    chk("lit_rs", 0, 32'(d0_rs), 32'd9);
    chk("lit_rt", 0, 32'(d0_rt), 32'd10);
    chk("lit_rd", 0, 32'(d0_rd), 32'd8);
    chk("lit_funct", 0, 32'(d0_funct), 32'h20);
    chk("lit_stamp1", 0, 32'(d0_stamp), 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lit_cls_i", 0, 32'(d0_class), 32'd4);
    chk("lit_imm_lui", 0, d0_imm, 32'h00001001);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lit_empty_valid", 0, 32'(d0_valid), 32'd0);
    chk("lit_empty_inst", 0, d0_inst, 32'd0);

    // Full handling: dut0 drops, dut1 overwrites
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, ADDU, 32'(i), 1'b0, 1'b0);
    chk("lit_full_cnt0", 0, 32'(d0_count), 32'd16);
    chk("lit_full_drop0", 0, 32'(d0_dropped), 32'd4);
    chk("lit_full_pc0", 0, d0_pc, 32'd0);
    chk("lit_full_cnt1", 1, 32'(d1_count), 32'd16);
    chk("lit_full_pc1", 1, d1_pc, 32'd4);
    chk("lit_full_drop1", 1, 32'(d1_dropped), 32'd0);
    cyc(1'b1, ADDU, 32'd20, 1'b1, 1'b0);
    chk("lit_pp_cnt0", 0, 32'(d0_count), 32'd16);
    chk("lit_pp_drop0", 0, 32'(d0_dropped), 32'd4);
    chk("lit_pp_pc0", 0, d0_pc, 32'd1);
    chk("lit_pp_pc1", 1, d1_pc, 32'd5);
    chk("lit_pp_stamp1", 1, 32'(d1_stamp), 32'd5);

    // Trigger on j with post-trigger capture
    trig_mask = 32'hFC000000;
    trig_match = 32'h08000000;
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, ADDU, 32'(16'h100 + i * 4), 1'b0, 1'b0);
    cyc(1'b1, JUMP, 32'h10C, 1'b0, 1'b0);
    chk("lit_post_state", 0, 32'(d0_state), 32'd2);
    for (int i = 0; i < 6; i++) cyc(1'b1, ADDU, 32'(16'h110 + i * 4), 1'b0, 1'b0);
    chk("lit_frz_state0", 0, 32'(d0_state), 32'd3);
    chk("lit_frz_cnt0", 0, 32'(d0_count), 32'd8);
    chk("lit_frz_state1", 1, 32'(d1_state), 32'd3);
    chk("lit_frz_cnt1", 1, 32'(d1_count), 32'd8);
    chk("lit_frz_drop", 0, 32'(d0_dropped), 32'd0);

    // Immediate extension, plus non-full push with pop
    trig_mask = 32'hFFFFFFFF;
    trig_match = 32'hDEADBEEF;
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'h3402FFFF, 32'h200, 1'b0, 1'b0);
    chk("lit_imm_ori", 0, d0_imm, 32'h0000FFFF);
    cyc(1'b1, 32'h2402FFFF, 32'h204, 1'b1, 1'b0);
    chk("lit_imm_addiu", 0, d0_imm, 32'hFFFFFFFF);
    chk("lit_pushpop_cnt", 0, 32'(d0_count), 32'd1);

    // Asynchronous reset in POST, then arm from FROZEN
    trig_mask = 32'hFC000000;
    trig_match = 32'h08000000;
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, ADDU, 32'(16'h300 + i * 4), 1'b0, 1'b0);
    cyc(1'b1, JUMP, 32'h310, 1'b0, 1'b0);
    chk("lit_pre_rst_cnt", 0, 32'(d0_count), 32'd5);
    chk("lit_pre_rst_state", 0, 32'(d0_state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_valid0", 0, 32'(d0_valid), 32'd0);
    chk("lit_arst_state0", 0, 32'(d0_state), 32'd0);
    chk("lit_arst_cnt0", 0, 32'(d0_count), 32'd0);
    chk("lit_arst_cnt1", 1, 32'(d1_count), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, ADDU, 32'(16'h400 + i * 4), 1'b0, 1'b0);
    cyc(1'b1, JUMP, 32'h408, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, ADDU, 32'(16'h40C + i * 4), 1'b0, 1'b0);
    chk("lit_f7_state", 0, 32'(d0_state), 32'd3);
    chk("lit_f7_cnt", 0, 32'(d0_count), 32'd7);
    cyc(1'b1, ADDU, 32'h500, 1'b0, 1'b1);
    chk("lit_rearm_cnt", 0, 32'(d0_count), 32'd0);
    chk("lit_rearm_state", 0, 32'(d0_state), 32'd1);
    cyc(1'b1, ADDU, 32'h504, 1'b0, 1'b0);
    chk("lit_rearm_stamp", 0, 32'(d0_stamp), 32'd0);
    chk("lit_rearm_pc", 0, d0_pc, 32'h504);

    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
